// File: rtl/button_conditioner_pkg.sv
// Shared types and default constants for the pushbutton conditioning stage.
package button_conditioner_pkg;

   // Per-channel auto-repeat FSM states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2
   } rep_state_e;

   // Defaults matched to the 4 Hz sample rate of the slow-clock stage
   localparam int unsigned DEFAULT_N_BTN          = 4;
   localparam int unsigned DEFAULT_STABLE_SAMPLES = 3;
   localparam int unsigned DEFAULT_REPEAT_DELAY   = 8;
   localparam int unsigned DEFAULT_REPEAT_RATE    = 2;

endpackage

// File: rtl/button_conditioner_if.sv
// Button bus: sample enable and raw keys in, conditioned levels and pulses out.
interface button_conditioner_if #(
   parameter int unsigned N_BTN = 4
);
   logic             sample_tick;
   logic [N_BTN-1:0] btn_raw;
   logic [N_BTN-1:0] btn_level;
   logic [N_BTN-1:0] btn_press;
   logic [N_BTN-1:0] btn_release;
   logic [N_BTN-1:0] btn_repeat;

   modport master (
      output sample_tick, btn_raw,
      input  btn_level, btn_press, btn_release, btn_repeat
   );

   modport slave (
      input  sample_tick, btn_raw,
      output btn_level, btn_press, btn_release, btn_repeat
   );
endinterface

// File: rtl/button_conditioner_channel.sv
// One pushbutton: 2-flop synchronizer, tick-sampled debounce, edge pulses
// and auto-repeat FSM.
module btn_debounce_channel
   import button_conditioner_pkg::*;
#(
   parameter bit          ACTIVE_LOW     = 1'b1,
   parameter int unsigned STABLE_SAMPLES = DEFAULT_STABLE_SAMPLES,
   parameter int unsigned REPEAT_DELAY   = DEFAULT_REPEAT_DELAY,
   parameter int unsigned REPEAT_RATE    = DEFAULT_REPEAT_RATE
) (
   input  logic clk_in,
   input  logic rst,
   input  logic sample_tick,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release,
   output logic btn_repeat
);

   localparam logic       RAW_RELEASED = ACTIVE_LOW ? 1'b1 : 1'b0;
   localparam logic [3:0] STABLE_MAX   = 4'(STABLE_SAMPLES);
   localparam logic [7:0] DELAY_MAX    = 8'(REPEAT_DELAY);
   localparam logic [7:0] RATE_MAX     = 8'(REPEAT_RATE);

   if (STABLE_SAMPLES < 1 || STABLE_SAMPLES > 15) begin : g_bad_stable
      $error("btn_debounce_channel: STABLE_SAMPLES out of range 1..15");
   end
   if (REPEAT_DELAY < 1 || REPEAT_DELAY > 255 ||
       REPEAT_RATE < 1 || REPEAT_RATE > 255) begin : g_bad_repeat
      $error("btn_debounce_channel: REPEAT_DELAY/REPEAT_RATE out of range 1..255");
   end

   logic       sync1_q, sync1_d;
   logic       sync2_q, sync2_d;
   logic       sync_n;
   logic [3:0] stab_cnt_q, stab_cnt_d, stab_inc;
   logic       level_q, level_d;
   logic       press_q, press_d;
   logic       release_q, release_d;
   logic       repeat_q, repeat_d;
   logic [7:0] rep_cnt_q, rep_cnt_d, rep_inc;
   rep_state_e state_q, state_d;

   // Next-state logic: debounce, edge detect and repeat FSM, all gated by sample_tick
   always_comb begin
      sync1_d    = btn_raw;
      sync2_d    = sync1_q;
      sync_n     = ACTIVE_LOW ? ~sync2_q : sync2_q;
      stab_inc   = stab_cnt_q + 4'd1;
      rep_inc    = rep_cnt_q + 8'd1;
      stab_cnt_d = stab_cnt_q;
      level_d    = level_q;
      press_d    = 1'b0;
      release_d  = 1'b0;
      repeat_d   = 1'b0;
      rep_cnt_d  = rep_cnt_q;
      state_d    = state_q;

      if (sample_tick) begin
         if (sync_n == level_q) begin
            stab_cnt_d = '0;
         end else if (stab_inc == STABLE_MAX) begin
            level_d    = ~level_q;
            stab_cnt_d = '0;
            press_d    = ~level_q;
            release_d  = level_q;
         end else begin
            stab_cnt_d = stab_inc;
         end

         // Release wins over a repeat falling due on the same tick; the
         // press tick itself only arms the delay count.
         if (release_d) begin
            state_d   = ST_IDLE;
            rep_cnt_d = '0;
         end else if (press_d) begin
            state_d   = ST_DELAY;
            rep_cnt_d = '0;
         end else begin
            case (state_q)
               ST_DELAY: begin
                  if (rep_inc == DELAY_MAX) begin
                     state_d   = ST_REPEAT;
                     repeat_d  = 1'b1;
                     rep_cnt_d = '0;
                  end else begin
                     rep_cnt_d = rep_inc;
                  end
               end
               ST_REPEAT: begin
                  if (rep_inc == RATE_MAX) begin
                     repeat_d  = 1'b1;
                     rep_cnt_d = '0;
                  end else begin
                     rep_cnt_d = rep_inc;
                  end
               end
               default: rep_cnt_d = '0;
            endcase
         end
      end
   end

   // State and registered outputs, asynchronously cleared
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         sync1_q    <= RAW_RELEASED;
         sync2_q    <= RAW_RELEASED;
         stab_cnt_q <= '0;
         level_q    <= 1'b0;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         repeat_q   <= 1'b0;
         rep_cnt_q  <= '0;
         state_q    <= ST_IDLE;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         stab_cnt_q <= stab_cnt_d;
         level_q    <= level_d;
         press_q    <= press_d;
         release_q  <= release_d;
         repeat_q   <= repeat_d;
         rep_cnt_q  <= rep_cnt_d;
         state_q    <= state_d;
      end
   end

   assign btn_level   = level_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;
   assign btn_repeat  = repeat_q;

endmodule

// File: rtl/button_conditioner.sv
// N-channel pushbutton conditioner driven by the slow-clock sample enable.
module button_conditioner
   import button_conditioner_pkg::*;
#(
   parameter int unsigned N_BTN          = DEFAULT_N_BTN,
   parameter bit          ACTIVE_LOW     = 1'b1,
   parameter int unsigned STABLE_SAMPLES = DEFAULT_STABLE_SAMPLES,
   parameter int unsigned REPEAT_DELAY   = DEFAULT_REPEAT_DELAY,
   parameter int unsigned REPEAT_RATE    = DEFAULT_REPEAT_RATE
) (
   input  logic          clk_in,
   input  logic          rst,
   button_conditioner_if.slave btn_if
);

   logic [N_BTN-1:0] level_w;
   logic [N_BTN-1:0] press_w;
   logic [N_BTN-1:0] release_w;
   logic [N_BTN-1:0] repeat_w;

   // One independent conditioner per button
   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      btn_debounce_channel #(
         .ACTIVE_LOW     (ACTIVE_LOW),
         .STABLE_SAMPLES (STABLE_SAMPLES),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_RATE    (REPEAT_RATE)
      ) u_ch (
         .clk_in      (clk_in),
         .rst         (rst),
         .sample_tick (btn_if.sample_tick),
         .btn_raw     (btn_if.btn_raw[i]),
         .btn_level   (level_w[i]),
         .btn_press   (press_w[i]),
         .btn_release (release_w[i]),
         .btn_repeat  (repeat_w[i])
      );
   end

   assign btn_if.btn_level   = level_w;
   assign btn_if.btn_press   = press_w;
   assign btn_if.btn_release = release_w;
   assign btn_if.btn_repeat  = repeat_w;

endmodule
